// File: rtl/mips_pkg.sv
// Shared register-file types for the writeback path.
package mips_pkg;

  typedef logic [4:0]  regaddr_t;
  typedef logic [31:0] word_t;

  typedef struct packed {
    regaddr_t rd;
    word_t    data;
  } wb_entry_t;

  localparam regaddr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO of pending long-latency writeback entries.
// full/empty derive from an occupancy count one bit wider than the pointers.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_push,
  input  wb_entry_t i_data,
  input  logic      i_pop,
  output wb_entry_t o_data,
  output logic      o_full,
  output logic      o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  wb_entry_t     r_mem [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: pipeline writeback wins, queued long-latency results fill gaps.
// Optional per-register pending scoreboard enabled by defining SCOREBOARD_EN.
module rf_write_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_regwrite,
  input  regaddr_t    pipe_writereg,
  input  word_t       pipe_result,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  regaddr_t    lu_reg,
  input  word_t       lu_data,
  output logic        we,
  output regaddr_t    a3,
  output word_t       wd3,
  output logic        stall_req
`ifdef SCOREBOARD_EN
  ,
  output logic [31:0] busy,
  input  logic        issue_valid,
  input  regaddr_t    issue_reg
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  logic      r_we;
  regaddr_t  r_a3;
  word_t     r_wd3;
  logic      r_stall;
  logic [SW-1:0] r_starve;
  logic [SW-1:0] w_starve_d;

  logic      w_pipe_wr;
  logic      w_push;
  logic      w_pop;
  logic      w_full;
  logic      w_empty;
  wb_entry_t w_head;
  wb_entry_t w_lu_entry;

  assign w_pipe_wr  = pipe_regwrite && (pipe_writereg != REG_ZERO);
  assign lu_ready   = !w_full;
  // r0 results are acknowledged but never occupy a slot.
  assign w_push     = lu_valid && lu_ready && (lu_reg != REG_ZERO);
  assign w_pop      = !w_empty && !w_pipe_wr;
  assign w_lu_entry = '{rd: lu_reg, data: lu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_lu_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_starve_d = r_starve;
    if (w_empty || w_pop) begin
      w_starve_d = '0;
    end else if (r_starve != SW'(STARVE_MAX)) begin
      w_starve_d = r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_a3     <= REG_ZERO;
      r_wd3    <= '0;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_starve <= w_starve_d;
      // Saturated count holds stall high until the next pop clears it.
      r_stall  <= (w_starve_d == SW'(STARVE_MAX));
      if (w_pipe_wr) begin
        r_we  <= 1'b1;
        r_a3  <= pipe_writereg;
        r_wd3 <= pipe_result;
      end else if (w_pop) begin
        r_we  <= 1'b1;
        r_a3  <= w_head.rd;
        r_wd3 <= w_head.data;
      end else begin
        r_we  <= 1'b0;
      end
    end
  end

  assign we        = r_we;
  assign a3        = r_a3;
  assign wd3       = r_wd3;
  assign stall_req = r_stall;

`ifdef SCOREBOARD_EN
  logic [31:0] r_busy;
  logic [31:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    if (w_pop) w_busy_d[w_head.rd] = 1'b0;
    // A same-cycle issue outranks the clear from the pop.
    if (issue_valid) w_busy_d[issue_reg] = 1'b1;
    w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_d;
  end

  assign busy = r_busy;
`endif

endmodule
